// File: rtl/axi_lite_read_poller_pkg.sv
// Shared definitions for the AXI4-Lite read poller.
//   - poll_state_e : FSM state encoding used by the top-level controller
//   - RESP_*       : AXI RRESP encodings
//   - resp_is_err  : true for any response other than OKAY
package axi_lite_read_poller_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        ADDR = 2'b01,
        DATA = 2'b10,
        HOLD = 2'b11
    } poll_state_e;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    // EXOKAY is meaningless for a plain AXI-Lite read, so it is flagged
    // together with the real error responses.
    function automatic logic resp_is_err(input logic [1:0] resp);
        logic err;
        err = 1'b1;
        case (resp)
            RESP_OKAY:                             err = 1'b0;
            RESP_EXOKAY, RESP_SLVERR, RESP_DECERR: err = 1'b1;
            default:                               err = 1'b1;
        endcase
        return err;
    endfunction

endpackage

// File: rtl/axi_lite_read_poller_poll_timer.sv
// Poll period timer.
// Counts cycles since the last poll was issued. A count of zero means a poll
// is due; the count stays at zero (poll pending) until the controller issues
// the next poll, so a busy controller polls late rather than skipping.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   clear      : force the count to zero (polling disabled)
//   restart    : a poll is being issued this cycle; count restarts at 1
//   expired    : count is zero, a poll is due
module axi_lite_read_poller_poll_timer #(
    parameter int unsigned POLL_PERIOD = 1000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic restart,
    output logic expired
);

    localparam int unsigned CW = (POLL_PERIOD > 2) ? $clog2(POLL_PERIOD) : 1;
    localparam logic [CW-1:0] LAST = CW'(POLL_PERIOD - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (restart) begin
            cnt_d = CW'(1);
        end else if (cnt_q == '0) begin
            // Saturate: poll pending until the controller takes it.
            cnt_d = '0;
        end else if (cnt_q == LAST) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired = (cnt_q == '0);

endmodule

// File: rtl/axi_lite_read_poller.sv
// AXI4-Lite read-only master that periodically reads one fixed register and
// hands each returned word to local logic through a one-entry output register.
// Ports:
//   M_AXI_ACLK, M_AXI_ARESETN : clock, asynchronous active-low reset
//   enable                    : polling enable
//   M_AXI_AR*                 : read address channel (ARADDR = TARGET_ADDR, ARPROT = 0)
//   M_AXI_R*                  : read data channel
//   sample_data/err/valid     : last captured word, error marker, valid
//   sample_ready              : consumer accepts the sample
//   timeout_flag              : sticky, an AR or R phase waited TIMEOUT_CYCLES
//   read_count                : completed R handshakes, wraps
//
// Handshakes: every channel transfers on a cycle where valid && ready are both
// high at the rising clock edge. A valid, once raised, stays high with stable
// payload until that transfer; ready may be raised or dropped freely.
module axi_lite_read_poller
    import axi_lite_read_poller_pkg::*;
#(
    parameter int unsigned C_M_AXI_ADDR_WIDTH = 32,
    parameter int unsigned C_M_AXI_DATA_WIDTH = 32,
    parameter logic [C_M_AXI_ADDR_WIDTH-1:0] TARGET_ADDR = '0,
    parameter int unsigned POLL_PERIOD    = 1000,
    parameter int unsigned TIMEOUT_CYCLES = 256
) (
    input  logic                          M_AXI_ACLK,
    input  logic                          M_AXI_ARESETN,
    input  logic                          enable,
    output logic                          M_AXI_ARVALID,
    output logic [C_M_AXI_ADDR_WIDTH-1:0] M_AXI_ARADDR,
    output logic [2:0]                    M_AXI_ARPROT,
    input  logic                          M_AXI_ARREADY,
    input  logic                          M_AXI_RVALID,
    input  logic [C_M_AXI_DATA_WIDTH-1:0] M_AXI_RDATA,
    input  logic [1:0]                    M_AXI_RRESP,
    output logic                          M_AXI_RREADY,
    output logic [C_M_AXI_DATA_WIDTH-1:0] sample_data,
    output logic                          sample_err,
    output logic                          sample_valid,
    input  logic                          sample_ready,
    output logic                          timeout_flag,
    output logic [15:0]                   read_count
);

    localparam int unsigned PW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [PW-1:0] PHASE_LIMIT = PW'(TIMEOUT_CYCLES);

    poll_state_e                   state_q, state_d;
    logic                          arvalid_q, arvalid_d;
    logic                          rready_q, rready_d;
    logic [C_M_AXI_DATA_WIDTH-1:0] sample_data_q, sample_data_d;
    logic                          sample_err_q, sample_err_d;
    logic                          sample_valid_q, sample_valid_d;
    logic                          timeout_q, timeout_d;
    logic [15:0]                   read_count_q, read_count_d;
    logic [PW-1:0]                 phase_cnt_q, phase_cnt_d;

    logic poll_due;
    logic poll_issue;
    logic timer_clear;
    logic phase_wait;
    logic [PW-1:0] phase_inc;

    assign timer_clear = (state_q == IDLE) && !enable;

    axi_lite_read_poller_poll_timer #(
        .POLL_PERIOD (POLL_PERIOD)
    ) u_poll_timer (
        .clk     (M_AXI_ACLK),
        .rst_n   (M_AXI_ARESETN),
        .clear   (timer_clear),
        .restart (poll_issue),
        .expired (poll_due)
    );

    assign phase_inc = phase_cnt_q + PW'(1);

    always_comb begin
        state_d        = state_q;
        arvalid_d      = arvalid_q;
        rready_d       = rready_q;
        sample_data_d  = sample_data_q;
        sample_err_d   = sample_err_q;
        sample_valid_d = sample_valid_q;
        timeout_d      = timeout_q;
        read_count_d   = read_count_q;
        phase_cnt_d    = phase_cnt_q;
        poll_issue     = 1'b0;
        phase_wait     = 1'b0;

        case (state_q)
            IDLE: begin
                if (!enable) begin
                    timeout_d = 1'b0;
                end else if (poll_due) begin
                    arvalid_d   = 1'b1;
                    poll_issue  = 1'b1;
                    phase_cnt_d = '0;
                    state_d     = ADDR;
                end
            end
            ADDR: begin
                // ARVALID is never withdrawn before the handshake, whatever
                // enable or the timeout do.
                if (arvalid_q && M_AXI_ARREADY) begin
                    arvalid_d   = 1'b0;
                    rready_d    = 1'b1;
                    phase_cnt_d = '0;
                    state_d     = DATA;
                end else begin
                    phase_wait = 1'b1;
                end
            end
            DATA: begin
                if (M_AXI_RVALID && rready_q) begin
                    sample_data_d  = M_AXI_RDATA;
                    sample_err_d   = resp_is_err(M_AXI_RRESP);
                    sample_valid_d = 1'b1;
                    rready_d       = 1'b0;
                    read_count_d   = read_count_q + 16'd1;
                    state_d        = HOLD;
                end else begin
                    phase_wait = 1'b1;
                end
            end
            HOLD: begin
                if (sample_valid_q && sample_ready) begin
                    sample_valid_d = 1'b0;
                    state_d        = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // Phase counter saturates at the limit; the flag sets on the cycle
        // the count reaches the limit and the transaction keeps waiting.
        if (phase_wait) begin
            if (phase_cnt_q != PHASE_LIMIT) begin
                phase_cnt_d = phase_inc;
            end
            if (phase_inc == PHASE_LIMIT) begin
                timeout_d = 1'b1;
            end
        end
    end

    always_ff @(posedge M_AXI_ACLK or negedge M_AXI_ARESETN) begin
        if (!M_AXI_ARESETN) begin
            state_q        <= IDLE;
            arvalid_q      <= 1'b0;
            rready_q       <= 1'b0;
            sample_data_q  <= '0;
            sample_err_q   <= 1'b0;
            sample_valid_q <= 1'b0;
            timeout_q      <= 1'b0;
            read_count_q   <= '0;
            phase_cnt_q    <= '0;
        end else begin
            state_q        <= state_d;
            arvalid_q      <= arvalid_d;
            rready_q       <= rready_d;
            sample_data_q  <= sample_data_d;
            sample_err_q   <= sample_err_d;
            sample_valid_q <= sample_valid_d;
            timeout_q      <= timeout_d;
            read_count_q   <= read_count_d;
            phase_cnt_q    <= phase_cnt_d;
        end
    end

    assign M_AXI_ARVALID = arvalid_q;
    assign M_AXI_ARADDR  = TARGET_ADDR;
    assign M_AXI_ARPROT  = 3'b000;
    assign M_AXI_RREADY  = rready_q;
    assign sample_data   = sample_data_q;
    assign sample_err    = sample_err_q;
    assign sample_valid  = sample_valid_q;
    assign timeout_flag  = timeout_q;
    assign read_count    = read_count_q;

endmodule
